// File: rtl/flash_pkg.sv
// Shared SPI-flash constants and the WIP-poll state encoding.
package flash_pkg;

  localparam logic [7:0] WR_EN_INST = 8'h06;
  localparam logic [7:0] SE_INST    = 8'h21;
  localparam logic [7:0] RDSR1_INST = 8'h05;
  localparam int         WIP_BIT    = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_READ  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6,
    ST_TOUT  = 3'd7
  } state_e;

endpackage

// File: rtl/flash_wip_poll_if.sv
// Control handshake plus the non-tristate SPI lines of the WIP poller.
interface flash_wip_poll_if;
  logic       start;
  logic       cs_n;
  logic       spi_clk;
  logic       io1;
  logic [7:0] status_byte;
  logic       busy;
  logic       poll_done;
  logic       timeout;

  modport master (
    input  start, io1,
    output cs_n, spi_clk, status_byte, busy, poll_done, timeout
  );

  modport slave (
    output start, io1,
    input  cs_n, spi_clk, status_byte, busy, poll_done, timeout
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// One-byte mode-0 SPI shifter at clk/4; runs while en is held, done on the last cycle.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);
  logic [1:0] phase;
  logic [2:0] bit_cnt;
  logic [7:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else if (!en) begin
      phase   <= '0;
      bit_cnt <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= {sr[6:0], miso};
      end
    end
  end

  // Counters wrap to zero after bit 7, so back-to-back bytes need no restart gap.
  assign sck     = en & phase[1];
  assign mosi    = en & tx_byte[~bit_cnt];
  assign done    = en & (phase == 2'd3) & (bit_cnt == 3'd7);
  assign rx_byte = {sr[6:0], miso};
endmodule

// File: rtl/flash_wip_poll.sv
// Polls flash status register 1 after an erase until WIP clears or MAX_POLLS expire.
module flash_wip_poll
  import flash_pkg::*;
#(
  parameter int          GAP_CYCLES = 32,
  parameter logic [15:0] MAX_POLLS  = 16'd60000
) (
  input  logic             system_clk,
  input  logic             system_reset_n,
  flash_wip_poll_if.master bus,
  inout  wire              io0
);
  localparam int CW = $clog2(GAP_CYCLES);

  state_e        state, nxt;
  logic [CW-1:0] cyc;
  logic [15:0]   poll_cnt;
  logic [7:0]    status_q, rx_byte;
  logic          sh_en, sh_done, sck, mosi, mosi_en;

  spi_byte_shifter u_shift (
    .clk     (system_clk),
    .rst_n   (system_reset_n),
    .en      (sh_en),
    .tx_byte (RDSR1_INST),
    .miso    (bus.io1),
    .sck     (sck),
    .mosi    (mosi),
    .done    (sh_done),
    .rx_byte (rx_byte)
  );

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state    <= ST_IDLE;
      cyc      <= '0;
      poll_cnt <= '0;
      status_q <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)   cyc <= '0;
      else if (cyc != '1) cyc <= cyc + CW'(1);
      if (state == ST_IDLE && bus.start) begin
        poll_cnt <= '0;
      end else if (state == ST_READ && sh_done) begin
        status_q <= rx_byte;
        if (poll_cnt != '1) poll_cnt <= poll_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) nxt = ST_SETUP;
      ST_SETUP: if (cyc == CW'(1)) nxt = ST_CMD;
      ST_CMD:   if (sh_done) nxt = ST_READ;
      ST_READ:  if (sh_done) nxt = ST_HOLD;
      // WIP is checked before the poll budget so a final clean read still wins.
      ST_HOLD:  if (cyc == CW'(1)) begin
                  if (!status_q[WIP_BIT])       nxt = ST_DONE;
                  else if (poll_cnt == MAX_POLLS) nxt = ST_TOUT;
                  else                            nxt = ST_GAP;
                end
      ST_GAP:   if (cyc == CW'(GAP_CYCLES - 1)) nxt = ST_SETUP;
      ST_DONE,
      ST_TOUT:  if (!bus.start) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  assign sh_en           = (state == ST_CMD) || (state == ST_READ);
  assign mosi_en         = (state == ST_SETUP) || (state == ST_CMD);
  assign io0             = mosi_en ? mosi : 1'bz;
  assign bus.cs_n        = !(state inside {ST_SETUP, ST_CMD, ST_READ, ST_HOLD});
  assign bus.spi_clk     = sck;
  assign bus.status_byte = status_q;
  assign bus.busy        = !(state inside {ST_IDLE, ST_DONE, ST_TOUT});
  assign bus.poll_done   = (state == ST_DONE);
  assign bus.timeout     = (state == ST_TOUT);
endmodule

// File: tb/tb_flash_wip_poll.sv
// Bench for flash_wip_poll: two instances (long budget / MAX_POLLS=3) against a cycle-level flash model.
module tb_flash_wip_poll;
  import flash_pkg::*;

  localparam int GAP = 32;

  logic system_clk = 1'b0;
  logic rst_n;
  logic [1:0] start_d;
  logic [1:0] io1_d;
  wire  io0_a, io0_b;

  always #5 system_clk = ~system_clk;

  flash_wip_poll_if bus_a ();
  flash_wip_poll_if bus_b ();

  flash_wip_poll #(.GAP_CYCLES(GAP), .MAX_POLLS(16'd60000)) dut_a (
    .system_clk(system_clk), .system_reset_n(rst_n), .bus(bus_a), .io0(io0_a));
  flash_wip_poll #(.GAP_CYCLES(GAP), .MAX_POLLS(16'd3)) dut_b (
    .system_clk(system_clk), .system_reset_n(rst_n), .bus(bus_b), .io0(io0_b));

  assign bus_a.start = start_d[0];
  assign bus_b.start = start_d[1];
  assign bus_a.io1   = io1_d[0];
  assign bus_b.io1   = io1_d[1];

  logic [1:0] cs_w, sck_w, io0_w, men_w, done_w, tout_w, busy_w;
  logic [7:0] stat_w [2];
  assign cs_w   = {bus_b.cs_n, bus_a.cs_n};
  assign sck_w  = {bus_b.spi_clk, bus_a.spi_clk};
  assign io0_w  = {io0_b, io0_a};
  assign men_w  = {dut_b.mosi_en, dut_a.mosi_en};
  assign done_w = {bus_b.poll_done, bus_a.poll_done};
  assign tout_w = {bus_b.timeout, bus_a.timeout};
  assign busy_w = {bus_b.busy, bus_a.busy};
  assign stat_w[0] = bus_a.status_byte;
  assign stat_w[1] = bus_b.status_byte;

  int n_cmp = 0;
  int n_bad = 0;

  // Flash model state: responses per poll of the current sequence, window tracking.
  logic [7:0] resp_tab [2][8];
  int  k [2];
  int  hi [2];
  int  nwin [2];
  int  base [2];
  bit  in_win [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window index k: 0-1 select setup, 2-33 command, 34-65 status read, 66-67 hold.
  function automatic logic exp_sck(input int kk);
    return (kk >= 2) && (kk < 66) && (((kk - 2) % 4) >= 2);
  endfunction

  function automatic logic exp_mosi(input int kk);
    logic [7:0] c;
    c = RDSR1_INST;
    if (kk < 2) return 1'b0;
    return c[3'(7 - (kk - 2) / 4)];
  endfunction

  // The correct bit is presented only in the sampling phase; other phases carry its inverse.
  function automatic logic flash_out(input logic [7:0] r, input int kk);
    logic b;
    b = r[3'(7 - (kk - 34) / 4)];
    return (((kk - 34) % 4) == 3) ? b : ~b;
  endfunction

  task automatic model_step(input bit i);
    int d;
    logic [2:0] w;
    if (!rst_n) begin
      in_win[i] = 1'b0;
      hi[i]     = 0;
      io1_d[i]  = 1'b0;
    end else if (!cs_w[i]) begin
      if (!in_win[i]) begin
        if (nwin[i] != base[i]) chk("gap_len", 32'(hi[i]), 32'(GAP));
        in_win[i] = 1'b1;
        k[i]      = 0;
        nwin[i]++;
      end
      chk("spi_clk", 32'(sck_w[i]), 32'(exp_sck(k[i])));
      chk("io0_driven", 32'(men_w[i]), 32'(k[i] < 34));
      if (k[i] < 34) chk("io0_bit", 32'(io0_w[i]), 32'(exp_mosi(k[i])));
      if (k[i] >= 34 && k[i] < 66) begin
        d = nwin[i] - 1 - base[i];
        w = (d > 7) ? 3'd7 : 3'(d);
        io1_d[i] = flash_out(resp_tab[i][w], k[i]);
      end else begin
        io1_d[i] = 1'b0;
      end
      k[i]++;
    end else begin
      if (in_win[i]) begin
        chk("win_len", 32'(k[i]), 32'd68);
        in_win[i] = 1'b0;
        hi[i]     = 0;
      end
      hi[i]++;
      chk("idle_spi_clk", 32'(sck_w[i]), 32'd0);
      chk("idle_io0_driven", 32'(men_w[i]), 32'd0);
      io1_d[i] = 1'b0;
    end
  endtask

  always @(negedge system_clk) begin
    model_step(1'b0);
    model_step(1'b1);
  end

  task automatic set_const(input bit i, input logic [7:0] v);
    for (int j = 0; j < 8; j++) resp_tab[i][j] = v;
  endtask

  task automatic fill_rand(input bit i, input int nb);
    for (int j = 0; j < 8; j++)
      resp_tab[i][j] = (j < nb) ? (8'($urandom) | 8'h01) : (8'($urandom) & 8'hFE);
  endtask

  task automatic check_idle(input bit i, input logic [7:0] st);
    chk("idle_cs_n", 32'(cs_w[i]), 32'd1);
    chk("idle_sck", 32'(sck_w[i]), 32'd0);
    chk("idle_mosi_en", 32'(men_w[i]), 32'd0);
    chk("idle_busy", 32'(busy_w[i]), 32'd0);
    chk("idle_poll_done", 32'(done_w[i]), 32'd0);
    chk("idle_timeout", 32'(tout_w[i]), 32'd0);
    chk("idle_status", 32'(stat_w[i]), 32'(st));
  endtask

  task automatic start_seq(input bit i);
    base[i]    = nwin[i];
    start_d[i] = 1'b1;
    @(negedge system_clk);
    chk("cs_fall_1cyc", 32'(cs_w[i]), 32'd0);
    chk("busy_on", 32'(busy_w[i]), 32'd1);
  endtask

  task automatic wait_end(input bit i);
    int n;
    n = 0;
    while (!(done_w[i] | tout_w[i]) && n < 3000) begin
      @(negedge system_clk);
      n++;
    end
    chk("seq_end_in_time", 32'(done_w[i] | tout_w[i]), 32'd1);
  endtask

  task automatic check_end(input bit i, input int polls, input logic dn, input logic [7:0] st);
    chk("poll_count", 32'(nwin[i] - base[i]), 32'(polls));
    chk("poll_done", 32'(done_w[i]), 32'(dn));
    chk("timeout", 32'(tout_w[i]), 32'(!dn));
    chk("status_byte", 32'(stat_w[i]), 32'(st));
    chk("end_busy", 32'(busy_w[i]), 32'd0);
    chk("end_cs_n", 32'(cs_w[i]), 32'd1);
  endtask

  task automatic finish_seq(input bit i, input logic [7:0] st);
    start_d[i] = 1'b0;
    repeat (2) @(negedge system_clk);
    check_idle(i, st);
  endtask

  initial begin
    int n, nb, mp, np;
    bit i;
    rst_n   = 1'b0;
    start_d = '0;
    set_const(1'b0, 8'h00);
    set_const(1'b1, 8'h00);
    repeat (3) @(negedge system_clk);
    check_idle(1'b0, 8'h00);
    check_idle(1'b1, 8'h00);
    #1 rst_n = 1'b1;
    @(negedge system_clk);
    check_idle(1'b0, 8'h00);

    // Ready on the first poll, then start held high in DONE.
    set_const(1'b0, 8'h00);
    start_seq(1'b0);
    wait_end(1'b0);
    check_end(1'b0, 1, 1'b1, 8'h00);
    repeat (20) @(negedge system_clk);
    chk("done_held", 32'(done_w[0]), 32'd1);
    chk("no_repoll_in_done", 32'(nwin[0] - base[0]), 32'd1);
    finish_seq(1'b0, 8'h00);

    // Three busy polls then ready, with start dropped and re-raised inside a gap.
    set_const(1'b0, 8'h02);
    for (int j = 0; j < 3; j++) resp_tab[0][j] = 8'h03;
    start_seq(1'b0);
    n = 0;
    while (!((nwin[0] - base[0]) == 1 && !in_win[0]) && n < 1000) begin
      @(negedge system_clk);
      #1 n++;
    end
    chk("reached_gap", 32'(cs_w[0]), 32'd1);
    start_d[0] = 1'b0;
    repeat (3) @(negedge system_clk);
    start_d[0] = 1'b1;
    wait_end(1'b0);
    check_end(1'b0, 4, 1'b1, 8'h02);
    finish_seq(1'b0, 8'h02);

    // Timeout at MAX_POLLS=3.
    set_const(1'b1, 8'h01);
    start_seq(1'b1);
    wait_end(1'b1);
    check_end(1'b1, 3, 1'b0, 8'h01);
    finish_seq(1'b1, 8'h01);

    // WIP clears on the very poll that reaches MAX_POLLS.
    set_const(1'b1, 8'h40);
    resp_tab[1][0] = 8'h01;
    resp_tab[1][1] = 8'h81;
    start_seq(1'b1);
    wait_end(1'b1);
    check_end(1'b1, 3, 1'b1, 8'h40);
    finish_seq(1'b1, 8'h40);

    // Asynchronous reset in the middle of status bit 4.
    set_const(1'b0, 8'h03);
    start_seq(1'b0);
    n = 0;
    while (!(in_win[0] && k[0] == 51) && n < 2000) begin
      @(negedge system_clk);
      #1 n++;
    end
    chk("reached_read_bit4", 32'(k[0]), 32'd51);
    rst_n      = 1'b0;
    start_d[0] = 1'b0;
    #1;
    check_idle(1'b0, 8'h00);
    check_idle(1'b1, 8'h00);
    repeat (2) @(negedge system_clk);
    #1 rst_n = 1'b1;
    @(negedge system_clk);
    check_idle(1'b0, 8'h00);
    set_const(1'b0, 8'hA4);
    start_seq(1'b0);
    wait_end(1'b0);
    check_end(1'b0, 1, 1'b1, 8'hA4);
    finish_seq(1'b0, 8'hA4);

    // Random busy-run lengths and status bytes on both instances.
    for (int it = 0; it < 6; it++) begin
      i  = 1'(it);
      nb = $urandom_range(0, 4);
      mp = i ? 3 : 60000;
      fill_rand(i, nb);
      repeat ($urandom_range(1, 8)) @(negedge system_clk);
      start_seq(i);
      wait_end(i);
      np = (nb + 1 <= mp) ? nb + 1 : mp;
      check_end(i, np, nb < mp, resp_tab[i][3'(np - 1)]);
      finish_seq(i, resp_tab[i][3'(np - 1)]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete (compared=%0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
